systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/tpu_pkg.sv | 15 +
 rtl/feeder_bank.sv | 34 +++
 rtl/systolic_feeder.sv | 180 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and feeder state encoding for the systolic array front end.
// Optional double-buffered operand storage is enabled with FEEDER_DBLBUF_EN.
package tpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int N          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/feeder_bank.sv
// NxN operand register file: one full-row write port, every element readable.
// Contents are cleared by reset and otherwise held until overwritten.
module feeder_bank #(
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int N          = tpu_pkg::N
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [1:0]                            wr_row,
    input  logic [DATA_WIDTH*N-1:0]               wr_data,
    output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   rd_data
);

    logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_row] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/systolic_feeder.sv
// Skewed A/B operand feeder for an NxN output-stationary systolic array.
// Define FEEDER_DBLBUF_EN for a shadow bank that can be loaded during a feed.
module systolic_feeder #(
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int N          = tpu_pkg::N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic                    ld_sel,
    input  logic [1:0]              ld_row,
    input  logic [DATA_WIDTH*N-1:0] ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH*N-1:0] a_out,
    output logic [DATA_WIDTH*N-1:0] b_out,
    output logic                    we_out
);

    localparam int TW = $clog2(3 * N);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;
    typedef logic [N-1:0][DATA_WIDTH-1:0]        vec_t;

    tpu_pkg::feeder_state_e state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    vec_t a_out_q, a_out_d;
    vec_t b_out_q, b_out_d;
    logic we_q, we_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic ld_fire, start_ok, byp;
    logic wr_a, wr_b;
    mat_t a_mem, b_mem, a_rd, b_rd;

    assign start_ok = start && (state_q == tpu_pkg::ST_IDLE);
    assign ld_fire  = ld_valid && ld_ready;
    assign wr_a     = ld_fire && !ld_sel;
    assign wr_b     = ld_fire && ld_sel;

`ifdef FEEDER_DBLBUF_EN
    logic act_q, act_d;
    mat_t a_m0, a_m1, b_m0, b_m1;

    assign ld_ready = 1'b1;
    assign act_d    = act_q ^ start_ok;
    // Loads hit the shadow bank; only at a swap does it become the read bank.
    assign byp      = start_ok;

    feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_a0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_a && act_q),
        .wr_row(ld_row), .wr_data(ld_data), .rd_data(a_m0)
    );
    feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_a1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_a && !act_q),
        .wr_row(ld_row), .wr_data(ld_data), .rd_data(a_m1)
    );
    feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_b0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_b && act_q),
        .wr_row(ld_row), .wr_data(ld_data), .rd_data(b_m0)
    );
    feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_b1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_b && !act_q),
        .wr_row(ld_row), .wr_data(ld_data), .rd_data(b_m1)
    );

    assign a_mem = act_d ? a_m1 : a_m0;
    assign b_mem = act_d ? b_m1 : b_m0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act_d;
        end
    end
`else
    assign ld_ready = (state_q == tpu_pkg::ST_IDLE);
    assign byp      = 1'b1;

    feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_a),
        .wr_row(ld_row), .wr_data(ld_data), .rd_data(a_mem)
    );
    feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_b),
        .wr_row(ld_row), .wr_data(ld_data), .rd_data(b_mem)
    );
`endif

    // A row written on the start edge must already be visible to step 0.
    always_comb begin
        a_rd = a_mem;
        b_rd = b_mem;
        for (int r = 0; r < N; r++) begin
            if (byp && ld_row == 2'(r)) begin
                if (wr_a) a_rd[r] = ld_data;
                if (wr_b) b_rd[r] = ld_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            tpu_pkg::ST_IDLE: begin
                if (start_ok) begin
                    state_d = tpu_pkg::ST_FEED;
                    t_d     = '0;
                end
            end
            tpu_pkg::ST_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = tpu_pkg::ST_DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            tpu_pkg::ST_DONE: begin
                state_d = tpu_pkg::ST_IDLE;
            end
            default: begin
                state_d = tpu_pkg::ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Element [i][k] of A and [i][k] of B both enter the array at step i+k.
    always_comb begin
        a_out_d = '0;
        b_out_d = '0;
        we_d    = (state_d == tpu_pkg::ST_FEED);
        busy_d  = (state_d != tpu_pkg::ST_IDLE);
        done_d  = (state_d == tpu_pkg::ST_DONE);
        if (we_d) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (t_d == TW'(i + k)) begin
                        a_out_d[i] = a_rd[i][k];
                        b_out_d[k] = b_rd[i][k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= tpu_pkg::ST_IDLE;
            t_q     <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_out  = a_out_q;
    assign b_out  = b_out_q;
    assign we_out = we_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table-driven bench for systolic_feeder with a small 4x4 array model.
// Also covers FEEDER_DBLBUF_EN builds when that macro is defined.
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic        ld_sel = 1'b0;
    logic [1:0]  ld_row = 2'd0;
    logic [31:0] ld_data = 32'd0;
    logic        start = 1'b0;
    logic        busy, done, we_out;
    logic [31:0] a_out, b_out;

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_WIDTH(8), .N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .a_out(a_out), .b_out(b_out), .we_out(we_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t tbl[12];
    int n_cmp = 0;
    int n_bad = 0;
    int acc[4][4];
    int ah[4][4];
    int bv[4][4];

`ifdef FEEDER_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] brow(input int r);
        return {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)};
    endfunction

    task automatic load(input logic sel, input logic [1:0] row, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = row;
        ld_data  = d;
        cyc();
        ld_valid = 1'b0;
    endtask

    task automatic array_step();
        for (int i = 3; i >= 0; i--) begin
            for (int j = 3; j >= 0; j--) begin
                ah[i][j] = (j == 0) ? int'(a_out[i*8 +: 8]) : ah[i][j-1];
                bv[i][j] = (i == 0) ? int'(b_out[j*8 +: 8]) : bv[i-1][j];
                acc[i][j] += ah[i][j] * bv[i][j];
            end
        end
    endtask

    task automatic run_table(input int scale, input bit ld_during, input bit use_arr);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int s = 0; s < 12; s++) begin
            chk($sformatf("a_s%0d", s), a_out, 32'(tbl[s].a * scale));
            chk($sformatf("b_s%0d", s), b_out, tbl[s].b);
            chk($sformatf("we_s%0d", s), 32'(we_out), 32'(tbl[s].we));
            chk($sformatf("busy_s%0d", s), 32'(busy), 32'(tbl[s].bsy));
            chk($sformatf("done_s%0d", s), 32'(done), 32'(tbl[s].dn));
            chk($sformatf("rdy_s%0d", s), 32'(ld_ready), 32'(DBL || s == 11));
            if (use_arr && we_out) array_step();
            if (ld_during && s < 8) begin
                ld_valid = 1'b1;
                ld_sel   = (s >= 4);
                ld_row   = 2'(s % 4);
                ld_data  = (s < 4) ? (32'h2 << (8 * s)) : brow(s - 4);
            end else begin
                ld_valid = 1'b0;
            end
            cyc();
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 12; s++) begin
            tbl[s].a   = 32'h0;
            tbl[s].b   = 32'h0;
            tbl[s].we  = (s < 10);
            tbl[s].bsy = (s < 11);
            tbl[s].dn  = (s == 10);
        end
        tbl[0].a = 32'h00000001;
        tbl[2].a = 32'h00000100;
        tbl[4].a = 32'h00010000;
        tbl[6].a = 32'h01000000;
        tbl[0].b = 32'h00000001;
        tbl[1].b = 32'h00000205;
        tbl[2].b = 32'h00030609;
        tbl[3].b = 32'h04070a0d;
        tbl[4].b = 32'h080b0e00;
        tbl[5].b = 32'h0c0f0000;
        tbl[6].b = 32'h10000000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc[i][j] = 0;
                ah[i][j]  = 0;
                bv[i][j]  = 0;
            end

        repeat (2) @(negedge clk);
        chk("rst_a", a_out, 32'h0);
        chk("rst_b", b_out, 32'h0);
        chk("rst_we", 32'(we_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdy", 32'(ld_ready), 32'h1);
        rst_n = 1'b1;
        cyc();

        for (int r = 0; r < 4; r++) begin
            load(1'b0, 2'(r), 32'h1 << (8 * r));
            load(1'b1, 2'(r), brow(r));
        end

        run_table(1, DBL, 1'b1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("c%0d%0d", i, j), 32'(acc[i][j]), 32'(4*i+j+1));

`ifdef FEEDER_DBLBUF_EN
        run_table(2, 1'b0, 1'b0);
`else
        run_table(1, 1'b0, 1'b0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_data  = 32'hffffffff;
        chk("rdy_in_feed", 32'(ld_ready), 32'h0);
        cyc();
        start    = 1'b0;
        ld_valid = 1'b0;
        repeat (7) cyc();
        chk("ign_done", 32'(done), 32'h1);
        chk("ign_busy", 32'(busy), 32'h1);
        cyc();
        chk("ign_idle_busy", 32'(busy), 32'h0);
        chk("ign_idle_we", 32'(we_out), 32'h0);
        cyc();
        chk("ign_no_restart", 32'(busy), 32'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ign_row0_kept", a_out, 32'h00000001);
        repeat (11) cyc();

        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd2;
        ld_data  = 32'h44332211;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
        ld_valid = 1'b0;
        cyc();
        cyc();
        chk("ldst_s2", a_out, 32'h00110100);
        cyc();
        chk("ldst_s3", a_out, 32'h00220000);
        cyc();
        chk("ldst_s4", a_out, 32'h00330000);
        cyc();
        chk("ldst_s5", a_out, 32'h00440000);
        repeat (6) cyc();
        chk("ldst_idle", 32'(busy), 32'h0);
`endif

        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        chk("mid_we", 32'(we_out), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_a", a_out, 32'h0);
        chk("mid_rst_b", b_out, 32'h0);
        chk("mid_rst_we", 32'(we_out), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_rdy", 32'(ld_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int s = 0; s < 10; s++) begin
            chk($sformatf("zero_a_s%0d", s), a_out, 32'h0);
            chk($sformatf("zero_b_s%0d", s), b_out, 32'h0);
            chk($sformatf("zero_we_s%0d", s), 32'(we_out), 32'h1);
            cyc();
        end
        chk("zero_done", 32'(done), 32'h1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
